// File: rtl/d_cache_pkg.sv
// Shared constants for the 2-way write-back data cache: FSM encoding,
// default geometry and the kseg1 segment code used by the optional bypass.
package d_cache_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t WB     = 2'd1;
  localparam state_t REFILL = 2'd2;

  localparam int DEF_A_WIDTH    = 32;
  localparam int DEF_C_INDEX    = 6;
  localparam int DEF_C_OFFSET   = 2;
  localparam int DEF_T_WIDTH    = DEF_A_WIDTH - DEF_C_INDEX - DEF_C_OFFSET - 2;
  localparam int DEF_LINE_WORDS = 1 << DEF_C_OFFSET;

  localparam logic [2:0] UNCACHED_SEG = 3'b101;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  wen);
    logic [31:0] merged;
    for (int b = 0; b < 4; b++)
      merged[8*b +: 8] = wen[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    return merged;
  endfunction

endpackage

// File: rtl/d_cache_way.sv
// One way of the data cache: valid/dirty/tag per set plus the line data.
// Reads are asynchronous; writes are either a CPU byte merge or a refill word.
module d_cache_way
  import d_cache_pkg::*;
#(
  parameter int T_WIDTH    = DEF_T_WIDTH,
  parameter int C_INDEX    = DEF_C_INDEX,
  parameter int C_OFFSET   = DEF_C_OFFSET,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [C_INDEX-1:0] index,
  input  logic [C_OFFSET-1:0] word,
  input  logic [T_WIDTH-1:0] tag_in,
  input  logic               write_en,
  input  logic [3:0]         write_wen,
  input  logic [31:0]        write_data,
  input  logic               fill_en,
  input  logic [31:0]        fill_data,
  input  logic               install,
  output logic               valid,
  output logic               dirty,
  output logic [T_WIDTH-1:0] tag,
  output logic [31:0]        rdata
);

  localparam int SETS = 1 << C_INDEX;

  logic [SETS-1:0]    valid_q;
  logic [SETS-1:0]    dirty_q;
  logic [T_WIDTH-1:0] tag_q  [SETS];
  logic [31:0]        data_q [SETS][LINE_WORDS];

  assign valid = valid_q[index];
  assign dirty = dirty_q[index];
  assign tag   = tag_q[index];
  assign rdata = data_q[index][word];

  // Installing a line always leaves it clean, even if a write hit was pending.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (install) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (write_en) begin
      dirty_q[index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (install)
      tag_q[index] <= tag_in;
    if (fill_en)
      data_q[index][word] <= fill_data;
    else if (write_en)
      data_q[index][word] <= merge_bytes(data_q[index][word], write_data, write_wen);
  end

endmodule

// File: rtl/d_cache_wb.sv
// 2-way set-associative write-back, write-allocate data cache with LRU and
// burst line refill. Define DCACHE_UNCACHED_EN to let kseg1 bypass the cache.
module d_cache_wb
  import d_cache_pkg::*;
#(
  parameter int A_WIDTH  = DEF_A_WIDTH,
  parameter int C_INDEX  = DEF_C_INDEX,
  parameter int C_OFFSET = DEF_C_OFFSET
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [A_WIDTH-1:0] p_a,
  input  logic [31:0]        p_dout,
  output logic [31:0]        p_din,
  input  logic               p_strobe,
  input  logic               p_rw,
  input  logic [3:0]         p_wen,
  output logic               p_ready,
  output logic               cache_miss,
  output logic [A_WIDTH-1:0] m_a,
  input  logic [31:0]        m_dout,
  output logic [31:0]        m_din,
  output logic               m_strobe,
  output logic               m_rw,
  output logic [3:0]         m_wen,
  input  logic               m_ready
);

  localparam int T_WIDTH    = A_WIDTH - C_INDEX - C_OFFSET - 2;
  localparam int LINE_WORDS = 1 << C_OFFSET;
  localparam int SETS       = 1 << C_INDEX;
  localparam logic [C_OFFSET-1:0] LAST_BEAT = C_OFFSET'(LINE_WORDS - 1);

  logic [T_WIDTH-1:0]  tag;
  logic [C_INDEX-1:0]  index;
  logic [C_OFFSET-1:0] word;
  logic                unused_addr;

  assign tag         = p_a[A_WIDTH-1:C_INDEX+C_OFFSET+2];
  assign index       = p_a[C_INDEX+C_OFFSET+1:C_OFFSET+2];
  assign word        = p_a[C_OFFSET+1:2];
  assign unused_addr = ^p_a[1:0];

  state_t              state_q;
  logic [C_OFFSET-1:0] beat_q;
  logic                victim_q;
  logic [SETS-1:0]     lru_q;

  logic [1:0]          way_valid, way_dirty, way_hit;
  logic [1:0]          way_we, way_fill, way_install;
  logic [T_WIDTH-1:0]  way_tag   [2];
  logic [31:0]         way_rdata [2];
  logic [C_OFFSET-1:0] way_word;

  logic uncached, cached_req, hit, victim_new, victim;

`ifdef DCACHE_UNCACHED_EN
  assign uncached = (p_a[A_WIDTH-1 -: 3] == UNCACHED_SEG);
`else
  assign uncached = 1'b0;
`endif

  assign cached_req = p_strobe & ~uncached & (state_q == IDLE);
  assign hit        = |way_hit;
  assign victim_new = ~way_valid[0] ? 1'b0 : (~way_valid[1] ? 1'b1 : lru_q[index]);
  assign victim     = (state_q == IDLE) ? victim_new : victim_q;
  assign way_word   = (state_q == IDLE) ? word : beat_q;

  for (genvar g = 0; g < 2; g++) begin : g_way
    assign way_hit[g]     = way_valid[g] & (way_tag[g] == tag);
    assign way_we[g]      = cached_req & p_rw & way_hit[g];
    assign way_fill[g]    = (state_q == REFILL) & m_ready & (victim == 1'(g));
    assign way_install[g] = way_fill[g] & (beat_q == LAST_BEAT);

    d_cache_way #(
      .T_WIDTH   (T_WIDTH),
      .C_INDEX   (C_INDEX),
      .C_OFFSET  (C_OFFSET),
      .LINE_WORDS(LINE_WORDS)
    ) u_way (
      .clk       (clk),
      .clrn      (clrn),
      .index     (index),
      .word      (way_word),
      .tag_in    (tag),
      .write_en  (way_we[g]),
      .write_wen (p_wen),
      .write_data(p_dout),
      .fill_en   (way_fill[g]),
      .fill_data (m_dout),
      .install   (way_install[g]),
      .valid     (way_valid[g]),
      .dirty     (way_dirty[g]),
      .tag       (way_tag[g]),
      .rdata     (way_rdata[g])
    );
  end

  always_comb begin
    p_din      = way_hit[1] ? way_rdata[1] : way_rdata[0];
    p_ready    = 1'b0;
    cache_miss = 1'b0;
    m_a        = {tag, index, beat_q, 2'b00};
    m_din      = way_rdata[victim];
    m_strobe   = 1'b0;
    m_rw       = 1'b0;
    m_wen      = 4'hF;
    case (state_q)
      WB: begin
        cache_miss = 1'b1;
        m_strobe   = 1'b1;
        m_rw       = 1'b1;
        m_a        = {way_tag[victim], index, beat_q, 2'b00};
      end
      REFILL: begin
        cache_miss = 1'b1;
        m_strobe   = 1'b1;
      end
      default: begin
`ifdef DCACHE_UNCACHED_EN
        if (uncached) begin
          m_a      = p_a;
          m_strobe = p_strobe;
          m_rw     = p_rw;
          m_din    = p_dout;
          m_wen    = p_wen;
          p_din    = m_dout;
          p_ready  = p_strobe & m_ready;
        end else
`endif
        begin
          p_ready    = p_strobe & hit;
          cache_miss = p_strobe & ~hit;
        end
      end
    endcase
  end

  // LRU names the way to evict next, so every touch points it at the other way.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      victim_q <= 1'b0;
      lru_q    <= '0;
    end else begin
      case (state_q)
        WB: begin
          if (m_ready) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == LAST_BEAT)
              state_q <= REFILL;
          end
        end
        REFILL: begin
          if (m_ready) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == LAST_BEAT) begin
              state_q      <= IDLE;
              lru_q[index] <= ~victim_q;
            end
          end
        end
        default: begin
          if (cached_req) begin
            if (hit) begin
              lru_q[index] <= way_hit[0];
            end else begin
              victim_q <= victim_new;
              state_q  <= (way_valid[victim_new] & way_dirty[victim_new]) ? WB : REFILL;
            end
          end
        end
      endcase
    end
  end

endmodule
